serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/fa_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Purpose : shared types and constants for the bit-serial adder controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, bit-counter width.
package serial_add_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to count bit positions 0..31, which covers WIDTH up to 32
    localparam int CNT_W = 5;

endpackage

// File: rtl/fa_cell.sv
// Purpose : one-bit full adder used by the serial adder datapath.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : a, b, cin -> sum, cout.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial adder: sum = a + b + cin, one bit per cycle, LSB first.
// Latency : start at edge k -> done pulse after edge k+WIDTH; next start taken at edge k+WIDTH+1.
// Backpressure: start is ignored while RUN is in progress; no queuing.
// Ports   : clk, rst (sync, active-high), start, a, b, cin in;
//           busy, done, sum, cout, ovf out (all registered).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_sum_shift;

    fa_cell u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB; written as shift+or so WIDTH=1 needs no special case
    assign w_sum_shift = (r_sum_sr >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_shift;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        // r_carry is the carry into the MSB during this last step,
                        // so overflow is resolved here and registered with the result.
                        r_sum   <= w_sum_shift;
                        r_cout  <= w_fa_cout;
                        r_ovf   <= r_carry ^ w_fa_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The edge that ends the done cycle may take a new start, which
                    // gives a WIDTH+1 cycle period when start is held high.
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t       tbl[7];
    logic [7:0] qa[40];
    logic [7:0] qb[40];
    logic       qc[40];

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Reference: plain modular arithmetic; signed overflow from operand/result signs
    function automatic res_t ref_add(input int w, input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] mask;
        logic [32:0] full;
        res_t        r;
        mask   = (33'd1 << w) - 33'd1;
        full   = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, c};
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 8-bit DUT; operands and (optionally) start are
    // scrambled after acceptance to show they have no effect.
    task automatic do_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [7:0] es, input logic ec,
                          input logic eo, input bit noise);
        int edges    = 0;
        int busy_cnt = 0;
        bit seen     = 0;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            if (busy8) busy_cnt++;
            if (done8) seen = 1;
            else begin
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                cin8   = 1'($urandom);
                start8 = noise ? 1'($urandom) : 1'b0;
            end
        end
        start8 = 1'b0;
        check({tag, " latency"}, edges, 9);
        check({tag, " sum"}, sum8, es);
        check({tag, " cout"}, cout8, ec);
        check({tag, " ovf"}, ovf8, eo);
        check({tag, " busy cycles"}, busy_cnt, 9);
        tick();
        check({tag, " done pulse width"}, done8, 1'b0);
        check({tag, " busy after"}, busy8, 1'b0);
        a8 = 8'($urandom); b8 = 8'($urandom);
        tick();
        check({tag, " sum held"}, sum8, es);
    endtask

    initial begin
        res_t r;
        bit   seen_done;
        int   n_done;

        tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        tbl[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        tbl[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        tbl[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        tbl[6] = '{a: 8'h55, b: 8'h2A, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        tick();
        tick();
        check("reset busy8", busy8, 1'b0);
        check("reset done8", done8, 1'b0);
        check("reset sum8", sum8, 8'h00);
        check("reset cout8", cout8, 1'b0);
        check("reset ovf8", ovf8, 1'b0);
        check("reset busy1", busy1, 1'b0);
        check("reset sum1", sum1, 1'b0);
        rst = 1'b0;
        tick();

        // Directed table; odd entries also hammer start during RUN
        for (int i = 0; i < 7; i++)
            do_op8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].sum, tbl[i].cout, tbl[i].ovf, bit'(i % 2));

        // Reset during RUN cycle 4, with start asserted on the same edge
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("abort busy before rst", busy8, 1'b1);
        repeat (3) tick();
        rst = 1'b1; start8 = 1'b1;
        tick();
        check("abort busy", busy8, 1'b0);
        check("abort sum", sum8, 8'h00);
        check("abort done", done8, 1'b0);
        rst = 1'b0; start8 = 1'b0;
        seen_done = 0;
        repeat (12) begin
            tick();
            if (done8) seen_done = 1;
        end
        check("abort no done", seen_done, 1'b0);
        do_op8("post-abort", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);

        // Randomized single operations against the model
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            r  = ref_add(8, {24'd0, ra}, {24'd0, rb}, rc);
            do_op8($sformatf("rnd%0d", i), ra, rb, rc, r.sum[7:0], r.cout, r.ovf, bit'($urandom % 2));
        end

        // Back-to-back, start held high: accepts at edges 0, 9, 18, 27
        n_done = 0;
        start8 = 1'b1;
        for (int e = 0; e < 36; e++) begin
            qa[e] = 8'($urandom); qb[e] = 8'($urandom); qc[e] = 1'($urandom);
            a8 = qa[e]; b8 = qb[e]; cin8 = qc[e];
            tick();
            check($sformatf("b2b8 done e%0d", e), done8, (e % 9) == 8);
            if ((e % 9) == 8) begin
                n_done++;
                r = ref_add(8, {24'd0, qa[e-8]}, {24'd0, qb[e-8]}, qc[e-8]);
                check($sformatf("b2b8 sum e%0d", e), sum8, r.sum[7:0]);
                check($sformatf("b2b8 cout e%0d", e), cout8, r.cout);
                check($sformatf("b2b8 ovf e%0d", e), ovf8, r.ovf);
            end
        end
        start8 = 1'b0;
        check("b2b8 done count", n_done, 4);
        tick();
        tick();

        // WIDTH=1, start held high: period 2; first ops are 1+1+1
        for (int e = 0; e < 16; e++) begin
            if (e < 4) begin
                qa[e] = 8'd1; qb[e] = 8'd1; qc[e] = 1'b1;
            end else begin
                qa[e] = 8'($urandom_range(0, 1)); qb[e] = 8'($urandom_range(0, 1)); qc[e] = 1'($urandom);
            end
            a1 = qa[e][0]; b1 = qb[e][0]; cin1 = qc[e]; start1 = 1'b1;
            tick();
            check($sformatf("w1 done e%0d", e), done1, (e % 2) == 1);
            if (e == 1) begin
                check("w1 1+1+1 sum", sum1, 1'b1);
                check("w1 1+1+1 cout", cout1, 1'b1);
                check("w1 1+1+1 ovf", ovf1, 1'b0);
            end
            if ((e % 2) == 1) begin
                r = ref_add(1, {24'd0, qa[e-1]}, {24'd0, qb[e-1]}, qc[e-1]);
                check($sformatf("w1 sum e%0d", e), sum1, r.sum[0]);
                check($sformatf("w1 cout e%0d", e), cout1, r.cout);
                check($sformatf("w1 ovf e%0d", e), ovf1, r.ovf);
            end
        end
        start1 = 1'b0;
        tick();
        check("w1 idle busy", busy1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
